// File: rtl/wbp_pkg.sv
// Shared types and helpers for the Wishbone pipelined SRAM target.
package wbp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } wbp_tgt_state_e;

  localparam logic [1:0] WBP_W_BYTE = 2'b01;
  localparam logic [1:0] WBP_W_HALF = 2'b10;
  localparam logic [1:0] WBP_W_WORD = 2'b11;

  // A byte access must hit exactly one lane; a half access must hit one aligned half.
  function automatic logic wbp_sel_legal(input logic [1:0] width, input logic [3:0] sel);
    logic [2:0] ones;
    ones = 3'(sel[0]) + 3'(sel[1]) + 3'(sel[2]) + 3'(sel[3]);
    case (width)
      WBP_W_BYTE: return (ones == 3'd1);
      WBP_W_HALF: return (sel == 4'b0011) || (sel == 4'b1100);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle shared by controller and peripheral.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ack;
  logic        err;
  logic        stall;

  modport peripheral (
    input  cyc, stb, we, addr, sel, data_wr,
    output data_rd, ack, err, stall
  );

  modport controller (
    output cyc, stb, we, addr, sel, data_wr,
    input  data_rd, ack, err, stall
  );
endinterface

// File: rtl/sram_bytewe.sv
// Single-port 32-bit SRAM with per-byte write enables and registered read (block-RAM style).
module sram_bytewe #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wbp_sram_target.sv
// Wishbone pipelined SRAM target with programmable wait states.
// Optional write protection of the lowest words: define WBP_SRAM_WRITE_PROTECT_EN.
module wbp_sram_target
  import wbp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned PROTECT_WORDS = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  wishbone_if.peripheral    wb,
  input  logic [1:0]        i_width_hint,
  input  logic              i_wp_enable
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS4  = 4'(WAIT_STATES);

  wbp_tgt_state_e state;
  logic [3:0]     cnt;
  logic           ack_q;
  logic           err_q;
  logic           rd_pend;
  logic [31:0]    hold_q;
  logic [31:0]    sram_q;

  logic [31:0]    off;
  logic [AW-1:0]  idx;
  logic           in_range;
  logic           accept;
  logic           wp_hit;
  logic           wr_bad;
  logic           bad;
  logic           mem_en;
  logic [3:0]     we_bytes;
  logic           unused_bits;

  assign off      = wb.addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign in_range = ({1'b0, off} < SPAN);
  assign accept   = wb.cyc && wb.stb && (state == IDLE);

`ifdef WBP_SRAM_WRITE_PROTECT_EN
  assign wp_hit      = i_wp_enable && (32'(idx) < PROTECT_WORDS);
  assign unused_bits = ^off[1:0];
`else
  assign wp_hit      = 1'b0;
  assign unused_bits = ^{off[1:0], i_wp_enable, (PROTECT_WORDS != 0)};
`endif

  // Rejected requests never touch the array, so the write is gated here rather than in the FSM.
  assign wr_bad   = wb.we && (!wbp_sel_legal(i_width_hint, wb.sel) || wp_hit);
  assign bad      = !in_range || wr_bad;
  assign mem_en   = accept && !bad;
  assign we_bytes = {4{wb.we}} & wb.sel;

  sram_bytewe #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .i_clk (i_clk),
    .en    (mem_en),
    .we    (we_bytes),
    .addr  (idx),
    .wdata (wb.data_wr),
    .rdata (sram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_pend <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_pend <= !wb.we;
            if (bad) begin
              state <= ERR;
              err_q <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= RESP;
              ack_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WS4;
            end
          end
        end
        WAIT: begin
          if (!wb.cyc) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            ack_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (rd_pend) hold_q <= sram_q;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The SRAM output drives data_rd during the read ack; hold_q keeps it until the next read ack.
  assign wb.data_rd = (state == RESP && rd_pend) ? sram_q : hold_q;
  assign wb.ack     = ack_q;
  assign wb.err     = err_q;
  assign wb.stall   = (state != IDLE);

endmodule

// File: tb/tb_wbp_sram_target.sv
// Directed bench for wbp_sram_target with zero, three and five wait states.
module tb_wbp_sram_target;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] dwr;
  logic [1:0]  whint;
  logic        wp;

  logic [2:0]  acks, errs, stalls;
  logic [31:0] rds [3];

  int ncmp  = 0;
  int nfail = 0;

`ifdef WBP_SRAM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  wishbone_if wb0();
  wishbone_if wb3();
  wishbone_if wb5();

  assign wb0.cyc = cyc[0]; assign wb3.cyc = cyc[1]; assign wb5.cyc = cyc[2];
  assign wb0.stb = stb;    assign wb3.stb = stb;    assign wb5.stb = stb;
  assign wb0.we = we;      assign wb3.we = we;      assign wb5.we = we;
  assign wb0.addr = addr;  assign wb3.addr = addr;  assign wb5.addr = addr;
  assign wb0.sel = sel;    assign wb3.sel = sel;    assign wb5.sel = sel;
  assign wb0.data_wr = dwr; assign wb3.data_wr = dwr; assign wb5.data_wr = dwr;

  assign acks   = {wb5.ack, wb3.ack, wb0.ack};
  assign errs   = {wb5.err, wb3.err, wb0.err};
  assign stalls = {wb5.stall, wb3.stall, wb0.stall};
  assign rds[0] = wb0.data_rd;
  assign rds[1] = wb3.data_rd;
  assign rds[2] = wb5.data_rd;

  wbp_sram_target #(.WAIT_STATES(0), .PROTECT_WORDS(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .wb(wb0), .i_width_hint(whint), .i_wp_enable(wp)
  );
  wbp_sram_target #(.WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .wb(wb3), .i_width_hint(whint), .i_wp_enable(wp)
  );
  wbp_sram_target #(.WAIT_STATES(5)) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .wb(wb5), .i_width_hint(whint), .i_wp_enable(wp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the target idle; returns just after a rising edge.
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] dat, input logic [1:0] h,
                      output bit ack_seen, output bit err_seen, output int lat);
    we = w; addr = a; sel = s; dwr = dat; whint = h;
    cyc[d] = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    ack_seen = 1'b0; err_seen = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !(ack_seen || err_seen); i++) begin
      @(negedge clk);
      if (acks[d] || errs[d]) begin
        ack_seen = acks[d]; err_seen = errs[d]; lat = i;
      end
      @(posedge clk); #1;
    end
    cyc[d] = 1'b0;
    @(negedge clk);
    check("pulse one cycle", {31'd0, acks[d] | errs[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input int d, input string tag, input bit w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] dat, input logic [1:0] h,
                     input bit exp_err);
    bit ak, er;
    int lat, exp_lat;
    exp_lat = exp_err ? 1 : (d == 0) ? 1 : (d == 1) ? 4 : 6;
    xact(d, w, a, s, dat, h, ak, er, lat);
    check({tag, " ack"}, {31'd0, ak}, {31'd0, !exp_err});
    check({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, " latency"}, lat, exp_lat);
  endtask

  initial begin
    logic [8:0] smask, amask;
    bit seen;
    rst_n = 1'b0; cyc = 3'b000; stb = 1'b0; we = 1'b0; addr = '0;
    sel = '0; dwr = '0; whint = 2'b11; wp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack", {31'd0, acks[0]}, 32'd0);
    check("reset err", {31'd0, errs[0]}, 32'd0);
    check("reset stall", {29'd0, stalls}, 32'd0);
    check("reset data_rd", rds[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, "w10", 1, 32'h10, 4'hF, 32'hDEADBEEF, 2'b11, 0);
    run(0, "r10", 0, 32'h10, 4'hF, 32'h0, 2'b11, 0);
    check("r10 data", rds[0], 32'hDEADBEEF);

    run(0, "w10 full", 1, 32'h10, 4'hF, 32'h11223344, 2'b11, 0);
    run(0, "byte w12", 1, 32'h12, 4'b0100, 32'h00AA0000, 2'b01, 0);
    run(0, "r12", 0, 32'h12, 4'h1, 32'h0, 2'b11, 0);
    check("byte merge", rds[0], 32'h11AA3344);
    run(0, "byte bad sel", 1, 32'h12, 4'b0110, 32'h55555555, 2'b01, 1);
    check("hold after err", rds[0], 32'h11AA3344);
    run(0, "r10 again", 0, 32'h10, 4'hF, 32'h0, 2'b11, 0);
    check("bad byte no write", rds[0], 32'h11AA3344);

    run(0, "w14", 1, 32'h14, 4'hF, 32'hCAFEF00D, 2'b11, 0);
    run(0, "half w16", 1, 32'h16, 4'b1100, 32'h12340000, 2'b10, 0);
    run(0, "half bad sel", 1, 32'h14, 4'b0110, 32'h99999999, 2'b10, 1);
    run(0, "sel0 w14", 1, 32'h14, 4'b0000, 32'hFFFFFFFF, 2'b11, 0);
    run(0, "r14", 0, 32'h14, 4'hF, 32'h0, 2'b11, 0);
    check("half merge", rds[0], 32'h1234F00D);

    run(0, "w00", 1, 32'h0, 4'hF, 32'h01020304, 2'b11, 0);
    run(0, "oor read", 0, 32'h1000, 4'hF, 32'h0, 2'b11, 1);
    check("oor hold", rds[0], 32'h1234F00D);
    run(0, "oor write", 1, 32'h1000, 4'hF, 32'h99999999, 2'b11, 1);
    run(0, "r00", 0, 32'h0, 4'hF, 32'h0, 2'b11, 0);
    check("oor no alias write", rds[0], 32'h01020304);

    wp = 1'b0;
    run(0, "w08 unprot", 1, 32'h08, 4'hF, 32'h0BADF00D, 2'b11, 0);
    wp = 1'b1;
    run(0, "w08 prot", 1, 32'h08, 4'hF, 32'hA5A5A5A5, 2'b11, PROT);
    run(0, "r08 prot", 0, 32'h08, 4'hF, 32'h0, 2'b11, 0);
    check("prot data", rds[0], PROT ? 32'h0BADF00D : 32'hA5A5A5A5);
    wp = 1'b0;
    run(0, "w08 wp off", 1, 32'h08, 4'hF, 32'h77777777, 2'b11, 0);
    run(0, "r08 wp off", 0, 32'h08, 4'hF, 32'h0, 2'b11, 0);
    check("wp off data", rds[0], 32'h77777777);

    run(1, "u3 w20", 1, 32'h20, 4'hF, 32'h13579BDF, 2'b11, 0);

    // Second request held from cycle 1 is taken once stall drops in cycle 5.
    we = 1'b0; addr = 32'h20; sel = 4'hF; cyc[1] = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    smask = '0; amask = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      smask[i-1] = stalls[1];
      amask[i-1] = acks[1];
      @(posedge clk); #1;
      if (i == 5) stb = 1'b0;
    end
    cyc[1] = 1'b0;
    check("u3 stall pattern", {23'd0, smask}, 32'h1EF);
    check("u3 ack pattern", {23'd0, amask}, 32'h108);
    check("u3 read data", rds[1], 32'h13579BDF);
    @(posedge clk); #1;

    we = 1'b1; addr = 32'h24; sel = 4'hF; dwr = 32'h2468ACE0; cyc[1] = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst stall", {31'd0, stalls[1]}, 32'd0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= acks[1] | errs[1]; end
    @(posedge clk); #1;
    rst_n = 1'b1; cyc[1] = 1'b0;
    repeat (6) begin @(negedge clk); seen |= acks[1] | errs[1]; end
    @(posedge clk); #1;
    check("rst no response", {31'd0, seen}, 32'd0);
    run(1, "u3 r24", 0, 32'h24, 4'hF, 32'h0, 2'b11, 0);
    check("rst write committed", rds[1], 32'h2468ACE0);

    we = 1'b1; addr = 32'h30; sel = 4'hF; dwr = 32'h0F1E2D3C; cyc[2] = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, stalls[2]}, 32'd1);
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort idle", {31'd0, stalls[2]}, 32'd0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= acks[2] | errs[2]; end
    @(posedge clk); #1;
    check("abort no response", {31'd0, seen}, 32'd0);
    run(2, "u5 r30", 0, 32'h30, 4'hF, 32'h0, 2'b11, 0);
    check("abort write committed", rds[2], 32'h0F1E2D3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
